// File: rtl/pmbist_march_engine_pkg.sv
// Shared definitions for the PMBIST march engine: instruction layout, FSM states
// and the polarity rule that turns the DATA field into a write/expected word.
package pmbist_march_engine_pkg;

  localparam int SCAN_WIDTH   = 24;
  localparam int DATA_FIELD_W = 8;
  localparam int ADMD_W       = 4;
  localparam int NO_W         = 2;

  // Field order mirrors the scan word from bit 23 down to bit 0.
  typedef struct packed {
    logic                    updwn;
    logic [3:0]              op;
    logic [3:0]              pol;
    logic [NO_W-1:0]         no;
    logic [DATA_FIELD_W-1:0] data;
    logic                    w;
    logic [ADMD_W-1:0]       admd;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CMP,
    ST_FIN
  } state_t;

  function automatic logic [DATA_FIELD_W-1:0] op_word(input instr_t ir,
                                                      input logic [NO_W-1:0] idx);
    return ir.pol[idx] ? ~ir.data : ir.data;
  endfunction

endpackage

// File: rtl/pmbist_addr_gen.sv
// Loadable up/down address counter over a power-of-two range starting at 0,
// with a flag marking the final address in the current walk direction.
module pmbist_addr_gen
  import pmbist_march_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_down,
  input  logic [ADMD_W-1:0]     load_admd,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic                  down_q;
  logic [ADDR_WIDTH-1:0] top_q;
  logic [ADDR_WIDTH-1:0] top_val;

  // Shifting all-ones by ADMD >= ADDR_WIDTH yields zero, so the mask saturates at the full range.
  assign top_val = ~({ADDR_WIDTH{1'b1}} << load_admd);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr   <= '0;
      down_q <= 1'b0;
      top_q  <= '0;
    end else if (load) begin
      down_q <= load_down;
      top_q  <= top_val;
      addr   <= load_down ? top_val : '0;
    end else if (step) begin
      addr <= down_q ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end
  end

  assign last = down_q ? (addr == '0) : (addr == top_q);

endmodule

// File: rtl/pmbist_march_engine.sv
// March engine: latches one instruction on ts, walks the address range applying
// up to four read/write ops per address, and records the first read mismatch.
module pmbist_march_engine
  import pmbist_march_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCAN_WIDTH-1:0] scan,
  input  logic                  ts,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  passfail,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  if (RD_LATENCY != 1 || DATA_WIDTH != DATA_FIELD_W) begin : g_bad_params
    $error("pmbist_march_engine: RD_LATENCY must be 1 and DATA_WIDTH must equal the DATA field");
  end

  state_t                state, state_nxt;
  instr_t                ir;
  instr_t                scan_i;
  logic [NO_W-1:0]       op_idx, op_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last;
  logic                  load, step, advance;
  logic                  start, mismatch;
  logic [DATA_WIDTH-1:0] exp_word;

  assign scan_i   = instr_t'(scan);
  assign start    = (state == ST_IDLE) && ts;
  assign exp_word = op_word(ir, op_idx);
  assign mismatch = (state == ST_CMP) && (mem_rdata != exp_word);

  pmbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_down (scan_i.updwn),
    .load_admd (scan_i.admd),
    .step      (step),
    .addr      (addr),
    .last      (last)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_idx;
    load      = 1'b0;
    step      = 1'b0;
    advance   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;

    unique case (state)
      ST_IDLE: begin
        if (ts) begin
          load      = 1'b1;
          op_nxt    = '0;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        mem_en    = 1'b1;
        mem_we    = ir.op[op_idx];
        mem_wdata = exp_word;
        if (ir.op[op_idx]) advance = 1'b1;
        else               state_nxt = ST_CMP;
      end
      ST_CMP: begin
        if (mismatch && ir.w) begin
          state_nxt = ST_FIN;
        end else begin
          advance   = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_FIN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Last op at an address either steps the address or, at the range end, finishes.
    if (advance) begin
      if (op_idx != ir.no) begin
        op_nxt = op_idx + NO_W'(1);
      end else begin
        op_nxt = '0;
        if (last) state_nxt = ST_FIN;
        else      step      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_idx    <= '0;
      ir        <= '0;
      passfail  <= 1'b1;
      fail_addr <= '0;
    end else begin
      state  <= state_nxt;
      op_idx <= op_nxt;
      if (start) begin
        ir        <= scan_i;
        passfail  <= 1'b1;
        fail_addr <= '0;
      end else if (mismatch && passfail) begin
        passfail  <= 1'b0;
        fail_addr <= addr;
      end
    end
  end

  assign mem_addr = addr;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);

endmodule

// File: tb/tb_pmbist_march_engine.sv
// Scoreboard bench for pmbist_march_engine: expected memory accesses and run
// results are queued by the stimulus and checked by an independent monitor.
module tb_pmbist_march_engine;
  import pmbist_march_engine_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  logic                  clk;
  logic                  rst;
  logic [SCAN_WIDTH-1:0] scan;
  logic                  ts;
  logic                  mem_en, mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata, mem_rdata;
  logic                  busy, done, passfail;
  logic [AW-1:0]         fail_addr;

  pmbist_march_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan      (scan),
    .ts        (ts),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .passfail  (passfail),
    .fail_addr (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory under test: 1-cycle read latency, optional stuck-at-0 on bit 0 of address 2.
  logic [DW-1:0] mem [16];
  logic          fault_en;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr] & ((fault_en && mem_addr == 4'd2) ? 8'hFE : 8'hFF);
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    int            cycles;
    logic          pf;
    logic [AW-1:0] fa;
  } res_t;

  acc_t acc_q[$];
  res_t res_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic updwn, input logic [3:0] op, input logic [3:0] pol,
                                input logic [1:0] no, input logic [7:0] data, input logic w,
                                input logic [3:0] admd);
    instr_t i;
    i.updwn = updwn; i.op = op; i.pol = pol; i.no = no;
    i.data = data; i.w = w; i.admd = admd;
    return i;
  endfunction

  function automatic void push_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t x;
    x.we = we; x.addr = a; x.wdata = d;
    acc_q.push_back(x);
  endfunction

  // Queue the access sequence of a run: n_addr addresses, all ops, stopping after stop_addr (-1 = none).
  function automatic void push_run(input instr_t i, input int n_addr, input int stop_addr,
                                   input int cycles, input logic pf, input logic [AW-1:0] fa);
    res_t r;
    for (int k = 0; k < n_addr; k++) begin
      int a;
      a = i.updwn ? n_addr - 1 - k : k;
      for (int o = 0; o <= int'(i.no); o++)
        push_acc(i.op[o], AW'(a), i.pol[o] ? ~i.data : i.data);
      if (a == stop_addr) break;
    end
    r.cycles = cycles; r.pf = pf; r.fa = fa;
    res_q.push_back(r);
  endfunction

  // Monitor: pops expectations whenever the DUT presents an access or a done pulse.
  int   busy_cnt  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after_fin", {31'd0, busy}, 32'd0);
      end
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_access: got addr %0h we %0b, expected none", mem_addr, mem_we);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          check("acc_we", {31'd0, mem_we}, {31'd0, e.we});
          check("acc_addr", {28'd0, mem_addr}, {28'd0, e.addr});
          if (e.we) check("acc_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("busy_cycles", busy_cnt, r.cycles);
          check("passfail", {31'd0, passfail}, {31'd0, r.pf});
          check("fail_addr", {28'd0, fail_addr}, {28'd0, r.fa});
          check("accesses_left", acc_q.size(), 0);
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
      prev_done = done;
    end
  end

  task automatic start(input instr_t i);
    @(negedge clk);
    scan = i;
    ts   = 1'b1;
    @(negedge clk);
    ts   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  instr_t s1, s3, s5;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s1 = mk(1'b0, 4'b0101, 4'b1100, 2'd3, 8'h00, 1'b0, 4'd2);
    s3 = mk(1'b0, 4'b0101, 4'b1100, 2'd3, 8'h00, 1'b1, 4'd2);
    s5 = mk(1'b1, 4'b0001, 4'b0000, 2'd0, 8'hA5, 1'b0, 4'd15);
    scan = '0; ts = 1'b0; fault_en = 1'b0; rst = 1'b0;

    #12;
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_mem_en",    {31'd0, mem_en},    32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  {28'd0, mem_addr},  32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_passfail",  {31'd0, passfail},  32'd1);
    check("rst_fail_addr", {28'd0, fail_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Scenario 1: fault-free, 6 cycles per address over 4 addresses.
    push_run(s1, 4, -1, 24, 1'b1, 4'd0);
    start(s1);
    wait_done(100);

    // Scenario 2: stuck-at fault at address 2, no stop.
    fault_en = 1'b1;
    push_run(s1, 4, -1, 24, 1'b0, 4'd2);
    start(s1);
    wait_done(100);

    // Scenario 3: same fault, stop on first fail after address 2 op3.
    push_run(s3, 4, 2, 18, 1'b0, 4'd2);
    start(s3);
    wait_done(100);

    // Result holds in IDLE, then an idle reset restores passfail.
    repeat (3) @(negedge clk);
    check("pf_hold",   {31'd0, passfail},  32'd0);
    check("fa_hold",   {28'd0, fail_addr}, 32'd2);
    rst = 1'b0;
    #1;
    check("idle_rst_passfail",  {31'd0, passfail},  32'd1);
    check("idle_rst_fail_addr", {28'd0, fail_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    fault_en = 1'b0;

    // Scenario 5: descending full-range single-write march.
    push_run(s5, 16, -1, 16, 1'b1, 4'd0);
    start(s5);
    wait_done(100);

    // ts re-pulsed mid-run with a different word must be ignored.
    push_run(s1, 4, -1, 24, 1'b1, 4'd0);
    start(s1);
    repeat (3) @(negedge clk);
    scan = s5;
    ts   = 1'b1;
    @(negedge clk);
    ts   = 1'b0;
    wait_done(100);

    // Reset in cycle 10 of a scenario-1 run: accesses of cycles 1,2,4,5,7,8 only.
    push_acc(1'b1, 4'd0, 8'h00);
    push_acc(1'b0, 4'd0, 8'h00);
    push_acc(1'b1, 4'd0, 8'hFF);
    push_acc(1'b0, 4'd0, 8'hFF);
    push_acc(1'b1, 4'd1, 8'h00);
    push_acc(1'b0, 4'd1, 8'h00);
    start(s1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy",     {31'd0, busy},     32'd0);
    check("abort_mem_en",   {31'd0, mem_en},   32'd0);
    check("abort_done",     {31'd0, done},     32'd0);
    check("abort_passfail", {31'd0, passfail}, 32'd1);
    check("abort_acc_left", acc_q.size(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);

    // A fresh start after the abort runs scenario 1 normally.
    push_run(s1, 4, -1, 24, 1'b1, 4'd0);
    start(s1);
    wait_done(100);
    repeat (2) @(negedge clk);
    check("results_left", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmbist_march_engine.md
Name: pmbist_march_engine

Overview:
Execution stage directly downstream of the scan instruction register in memory_ip_block.
- On a `ts` start strobe it latches one march instruction from `scan`.
- It walks the address range up or down, applying up to four read/write ops per address to the memory under test.
- It compares read data against expected data and reports a sticky `passfail` and the first failing address.

Parameters:
ADDR_WIDTH, 4, memory address bits (max range 2^ADDR_WIDTH words)
DATA_WIDTH, 8, memory word width; equals the instruction DATA field width
RD_LATENCY, 1, memory read latency in cycles; only 1 is supported

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
scan  in  SCAN_WIDTH(24)  march instruction word
ts  in  1  test start; sampled high in IDLE starts a run
mem_en  out  1  memory access enable
mem_we  out  1  1=write, 0=read (valid when mem_en=1)
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after read issue
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
passfail  out  1  1=no mismatch since last start; sticky 0 on mismatch
fail_addr  out  ADDR_WIDTH  address of first mismatch

Behaviour:
Instruction layout (bit positions):
- [23] UPDWN: 0=ascending, 1=descending.
- [22:19] OP3..OP0: 1=write, 0=read.
- [18:15] POL3..POL0: 0=DATA, 1=~DATA.
- [14:13] NO: op count minus 1.
- [12:5] DATA.
- [4] W: 1=stop on first fail.
- [3:0] ADMD: range = 2^min(ADMD,ADDR_WIDTH) words starting at address 0. ADMD=15 selects the full range; ADMD=0 selects address 0 only.

Reset (rst=0, async):
- state=IDLE.
- busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- passfail=1, fail_addr=0.
- Instruction register cleared.
- Reset mid-run aborts immediately; no done pulse.

State machine: IDLE, EXEC, CMP, FIN.
- IDLE: on a clock edge with ts=1:
  - latch scan into the instruction register;
  - passfail<=1, fail_addr<=0;
  - addr<=0 (up) or range-1 (down);
  - op<=0, busy<=1, go to EXEC.
  - ts=0: stay in IDLE.
- EXEC (op i, OP0 first):
  - mem_en=1, mem_we=OPi, mem_addr=addr, mem_wdata = POLi ? ~DATA : DATA.
  - Write: advance and stay in EXEC (1 cycle).
  - Read: go to CMP.
- CMP:
  - Compare mem_rdata against the expected word (same polarity rule as a write).
  - mem_en=0.
  - On mismatch while passfail=1: passfail<=0, fail_addr<=addr.
  - Mismatch with W=1: go to FIN.
  - Otherwise advance.
- Advance:
  - If op<NO: op++.
  - Else op<=0 and step the address.
  - After the last op at the last address (range-1 ascending, 0 descending): go to FIN. No address wrap-around.
- FIN: done=1 for one cycle, busy<=0, go to IDLE. passfail and fail_addr hold until the next start.

Timing and corner cases:
- Cycles per address = (#writes) + 2*(#reads) among ops 0..NO.
- busy is high from the cycle after ts is sampled through the FIN cycle.
- ts while busy: ignored. ts held high in IDLE after FIN: starts a new run.
- A second mismatch never overwrites fail_addr.
- Range of 1 word (ADMD=0): only address 0 is exercised, in either direction.

Decomposition:
- defines.v (shared):
  - SCAN_WIDTH;
  - field position/width constants and IR_* field macros for UPDWN, OP, POL, NO, DATA, W, ADMD;
  - state encodings.
- Sub-module pmbist_addr_gen: loadable up/down address counter with a range-size input, step enable, and a last-address flag.
- Op indexing, the compare, and the FSM stay in pmbist_march_engine.

Test Plan:
1. Common setup for scenarios 1–3:
   - ADDR_WIDTH=4, fault-free 1-cycle memory model.
   - scan: UPDWN=0, OP=4'b0101, POL=4'b1100, NO=3, DATA=8'h00, W=0, ADMD=2.
   - Ops per address: w00, r00, wFF, rFF.
2. Scenario 1, fault-free: pulse ts -> 24 busy cycles (6 per address), addresses 0,1,2,3; done one cycle; passfail=1; fail_addr=0.
3. Scenario 2, bit0 of address 2 stuck-at-0, W=0 -> full 24 cycles; passfail=0; fail_addr=2 (first mismatch on the rFF read).
4. Scenario 3, same fault with W=1 -> done pulses right after the address-2 op3 CMP cycle (cycle 18); no access to address 3; passfail=0; fail_addr=2.
5. UPDWN=1, NO=0, OP0=write, DATA=8'hA5, ADMD=15 -> 16 single-cycle writes at addresses 15 down to 0, all with mem_wdata=A5; done; passfail=1.
6. Robustness:
   - ts re-pulsed mid-run -> no effect on the instruction or address sequence.
   - rst=0 at cycle 10 -> busy=0, mem_en=0, passfail=1 asynchronously, no done pulse.
   - A subsequent ts runs scenario 1 correctly.
